// File: rtl/note_sequencer_if.sv
// Melody ROM bus between the note sequencer and its synchronous melody ROM.
// rom_data is expected one clk after rom_addr changes.
interface note_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/note_sequencer.sv
// Melody sequencer: walks note words in a synchronous ROM and drives the square-wave
// synthesiser's half-period and gate, with beat-based durations and an end-of-note gap.
module note_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int BEAT_DIV = 50000,
    parameter int GAP      = 2000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                loop,
    note_sequencer_if.master    rom,
    output logic [6:0]          hp,
    output logic                active,
    output logic                playing,
    output logic                beat,
    output logic                done
);

    localparam int CTR_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(BEAT_DIV - 1);
    // One extra bit so that GAP=0 (threshold == BEAT_DIV) never matches.
    localparam logic [CTR_W:0]   GAP_START = (CTR_W + 1)'(BEAT_DIV - GAP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_PLAY  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [6:0]          hp_r;
    logic [3:0]          beats_left_r;
    logic [CTR_W-1:0]    beat_ctr_r;
    logic                playing_r;
    logic                beat_r;
    logic                done_r;

    logic                eos_s;
    logic [6:0]          rom_hp_s;
    logic [3:0]          rom_dur_s;
    logic                wrap_s;
    logic                last_beat_s;
    logic                in_gap_s;

    assign eos_s       = rom.rom_data[11];
    assign rom_hp_s    = rom.rom_data[10:4];
    assign rom_dur_s   = rom.rom_data[3:0];
    assign wrap_s      = (beat_ctr_r == CTR_LAST);
    assign last_beat_s = (beats_left_r == 4'd0);
    assign in_gap_s    = last_beat_s && ({1'b0, beat_ctr_r} >= GAP_START);

    assign rom.rom_addr = addr_r;
    assign hp           = hp_r;
    assign playing      = playing_r;
    assign beat         = beat_r;
    assign done         = done_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; stop always wins and returns to IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (eos_s) begin
                    if (loop) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_nx_s = ST_IDLE;
                end else if (wrap_s && last_beat_s) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: address, note fields, beat timing and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r       <= {ADDR_W{1'b0}};
            hp_r         <= 7'd0;
            beats_left_r <= 4'd0;
            beat_ctr_r   <= {CTR_W{1'b0}};
            playing_r    <= 1'b0;
            beat_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            playing_r <= (state_nx_s != ST_IDLE);
            beat_r    <= 1'b0;
            done_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !stop) begin
                        addr_r <= {ADDR_W{1'b0}};
                    end
                end
                ST_LOAD: begin
                    if (!stop) begin
                        if (eos_s) begin
                            if (loop) begin
                                addr_r <= {ADDR_W{1'b0}};
                            end else begin
                                done_r <= 1'b1;
                            end
                        end else begin
                            hp_r         <= rom_hp_s;
                            beats_left_r <= rom_dur_s;
                            beat_ctr_r   <= {CTR_W{1'b0}};
                        end
                    end
                end
                ST_PLAY: begin
                    if (!stop) begin
                        if (wrap_s) begin
                            beat_ctr_r <= {CTR_W{1'b0}};
                            beat_r     <= 1'b1;
                            if (last_beat_s) begin
                                addr_r <= addr_r + ADDR_W'(1);
                            end else begin
                                beats_left_r <= beats_left_r - 4'd1;
                            end
                        end else begin
                            beat_ctr_r <= beat_ctr_r + CTR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Gate decoded from registered state only, so an async reset drops it at once.
    always_comb begin
        active = 1'b0;
        if ((state_r == ST_PLAY) && (hp_r != 7'd0) && !in_gap_s) begin
            active = 1'b1;
        end else begin
            active = 1'b0;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with BEAT_DIV=4, GAP=1, ADDR_W=3 and a behavioural ROM.
module tb_note_sequencer;

    localparam int ADDR_W = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [6:0]  hp;
    logic        active;
    logic        playing;
    logic        beat;
    logic        done;

    logic [11:0] rom_mem [0:7];
    logic [11:0] rom_q = 12'd0;

    int n_checks = 0;
    int n_pass   = 0;

    note_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    note_sequencer #(.ADDR_W(ADDR_W), .BEAT_DIV(4), .GAP(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .rom     (bus.master),
        .hp      (hp),
        .active  (active),
        .playing (playing),
        .beat    (beat),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[bus.rom_addr];
    assign bus.rom_data = rom_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_single_note();
        for (int i = 0; i < 8; i++) rom_mem[i] = 12'h800;
        rom_mem[0] = {1'b0, 7'd20, 4'd1};
    endtask

    initial begin
        int act_cnt, beat_cnt, done_cnt, first_act, gap_act, rest_act;
        int rise_n;
        int rises [0:3];
        logic prev_act;
        logic [6:0] hv;

        for (int i = 0; i < 8; i++) rom_mem[i] = 12'h800;

        // Reset state
        #2 rst_n = 1'b0;
        #3;
        check("rst_hp", hp, 0);
        check("rst_active", active, 0);
        check("rst_playing", playing, 0);
        check("rst_beat", beat, 0);
        check("rst_done", done, 0);
        check("rst_addr", bus.rom_addr, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single note: dur=1 -> 8 PLAY cycles, last one is the gap
        load_single_note();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sn_playing_fetch", playing, 1);
        check("sn_active_fetch", active, 0);
        act_cnt = 0; beat_cnt = 0; done_cnt = 0; first_act = 0; gap_act = 1;
        for (int k = 2; k <= 16; k++) begin
            tick();
            if (active) begin
                act_cnt++;
                if (first_act == 0) first_act = k;
            end
            beat_cnt += int'(beat);
            done_cnt += int'(done);
            if (k == 10) gap_act = int'(active);
        end
        check("sn_first_active", first_act, 3);
        check("sn_active_cycles", act_cnt, 7);
        check("sn_gap_active", gap_act, 0);
        check("sn_beats", beat_cnt, 2);
        check("sn_done_pulses", done_cnt, 1);
        check("sn_hp", hp, 20);
        check("sn_playing_end", playing, 0);

        // Rest followed by a dur=0 note
        for (int i = 0; i < 8; i++) rom_mem[i] = 12'h800;
        rom_mem[0] = {1'b0, 7'd0, 4'd0};
        rom_mem[1] = {1'b0, 7'd9, 4'd0};
        start = 1'b1;
        tick();
        start = 1'b0;
        act_cnt = 0; beat_cnt = 0; done_cnt = 0; rest_act = 0;
        for (int k = 2; k <= 18; k++) begin
            tick();
            if (active && k >= 3 && k <= 6) rest_act++;
            act_cnt += int'(active);
            beat_cnt += int'(beat);
            done_cnt += int'(done);
        end
        check("rest_active", rest_act, 0);
        check("rest_total_active", act_cnt, 3);
        check("rest_beats", beat_cnt, 2);
        check("rest_hp", hp, 9);
        check("rest_done", done_cnt, 1);

        // Loop: 8 PLAY + FETCH/LOAD of eos + FETCH/LOAD of note 0 = 12 cycles between note starts
        load_single_note();
        loop = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        prev_act = active;
        rise_n = 0; done_cnt = 0;
        for (int i = 0; i < 4; i++) rises[i] = 0;
        for (int k = 2; k <= 30; k++) begin
            tick();
            if (active && !prev_act && rise_n < 4) begin
                rises[rise_n] = k;
                rise_n++;
            end
            prev_act = active;
            done_cnt += int'(done);
            if (k == 11) check("loop_addr_eos", bus.rom_addr, 1);
            if (k == 13) check("loop_addr_restart", bus.rom_addr, 0);
            if (k == 23) check("loop_addr_eos2", bus.rom_addr, 1);
        end
        check("loop_first_rise", rises[0], 3);
        check("loop_period", rises[1] - rises[0], 12);
        check("loop_no_done", done_cnt, 0);
        loop = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loop_stopped", playing, 0);

        // Stop in the 3rd PLAY cycle
        load_single_note();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 5; k++) tick();
        check("stop_pre_active", active, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_active", active, 0);
        check("stop_playing", playing, 0);
        check("stop_hp", hp, 20);
        check("stop_done", done, 0);
        tick();
        tick();
        check("stop_done_later", done, 0);
        check("stop_idle", playing, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("replay_addr", bus.rom_addr, 0);
        check("replay_playing", playing, 1);
        tick();
        tick();
        check("replay_active", active, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Address wrap: 8 dur=0 notes, hp = addr+1, note-to-note period 6
        for (int i = 0; i < 8; i++) begin
            hv = 7'(i + 1);
            rom_mem[i] = {1'b0, hv, 4'd0};
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 63; k++) begin
            tick();
            if (k == 9)  check("wrap_hp_n1", hp, 2);
            if (k == 43) check("wrap_addr7", bus.rom_addr, 7);
            if (k == 45) check("wrap_hp_n7", hp, 8);
            if (k == 49) check("wrap_addr0", bus.rom_addr, 0);
            if (k == 51) begin
                check("wrap_hp_again", hp, 1);
                check("wrap_active_again", active, 1);
            end
            if (k == 63) check("wrap_addr2", bus.rom_addr, 2);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Start and stop together in IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("ss_playing", playing, 0);
        check("ss_addr", bus.rom_addr, 2);
        check("ss_active", active, 0);
        tick();
        check("ss_still_idle", playing, 0);

        // Async reset mid-PLAY
        load_single_note();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 2; k <= 4; k++) tick();
        check("ar_pre_active", active, 1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_active", active, 0);
        check("ar_playing", playing, 0);
        check("ar_hp", hp, 0);
        check("ar_addr", bus.rom_addr, 0);
        check("ar_beat", beat, 0);
        check("ar_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle", playing, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
